// File: rtl/jt6295_chseq.sv
// Time-multiplexed ADPCM channel sequencer: one channel slot per cen4, ROM nibble fetch per busy slot.
// Latency: rom_addr registered at the end of slot k, pipe_* registered at the end of slot k+1.
// No backpressure: the slot wheel free-runs on cen4, and start/stop are captured once per frame.
module jt6295_chseq #(
    parameter  int CH = 4,
    parameter  int AW = 18,
    localparam int CW = $clog2(CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen4,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] stop_addr,
    input  logic [3:0]    att,
    input  logic          loop,
    input  logic [CH-1:0] start,
    input  logic [CH-1:0] stop,
    output logic [CH-1:0] busy,
    output logic          zero,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic          pipe_en,
    output logic [3:0]    pipe_att,
    output logic [3:0]    pipe_data,
    output logic [CW-1:0] pipe_ch
);

    logic [CW-1:0] slot;
    logic [CH-1:0] start_q, stop_q;

    logic [AW:0]   cnt     [CH];
    logic [AW-1:0] stp_adr [CH];
    logic [AW-1:0] lp_adr  [CH];
    logic [3:0]    att_r   [CH];
    logic [CH-1:0] loop_r;

    // Fetch stage: tracks what the ROM is returning during the next slot
    logic          emit_q;
    logic          sel_q;
    logic [3:0]    att_q;
    logic [CW-1:0] ch_q;

    logic [AW:0]   cur_cnt;
    logic          at_end;

    assign zero    = (slot == CW'(CH-1));
    assign cur_cnt = cnt[slot];
    assign at_end  = cur_cnt[0] && (cur_cnt[AW:1] >= stp_adr[slot]);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot      <= '0;
            start_q   <= '0;
            stop_q    <= '0;
            busy      <= '0;
            loop_r    <= '0;
            rom_addr  <= '0;
            emit_q    <= 1'b0;
            sel_q     <= 1'b0;
            att_q     <= '0;
            ch_q      <= '0;
            pipe_en   <= 1'b0;
            pipe_att  <= '0;
            pipe_data <= '0;
            pipe_ch   <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt[i]     <= '0;
                stp_adr[i] <= '0;
                lp_adr[i]  <= '0;
                att_r[i]   <= '0;
            end
        end else if (cen4) begin
            slot <= zero ? '0 : CW'(slot + 1'b1);
            if (zero) begin
                start_q <= start;
                stop_q  <= stop;
            end

            pipe_en   <= emit_q;
            pipe_ch   <= ch_q;
            pipe_att  <= att_q;
            pipe_data <= sel_q ? rom_data[3:0] : rom_data[7:4];

            emit_q <= 1'b0;
            ch_q   <= slot;
            att_q  <= att_r[slot];
            sel_q  <= cur_cnt[0];

            // start outranks stop; both outrank playback
            if (start_q[slot]) begin
                cnt[slot]     <= {start_addr, 1'b0};
                lp_adr[slot]  <= start_addr;
                stp_adr[slot] <= stop_addr;
                att_r[slot]   <= att;
                loop_r[slot]  <= loop;
                busy[slot]    <= 1'b1;
            end else if (stop_q[slot]) begin
                busy[slot] <= 1'b0;
            end else if (busy[slot]) begin
                rom_addr <= cur_cnt[AW:1];
                emit_q   <= 1'b1;
                if (at_end && loop_r[slot]) begin
                    cnt[slot] <= {lp_adr[slot], 1'b0};
                end else begin
                    cnt[slot] <= cur_cnt + 1'b1;
                    if (at_end) busy[slot] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt6295_chseq.sv
// Scoreboard bench for jt6295_chseq: expected nibbles queued at stimulus time, popped on pipe_en.
module tb_jt6295_chseq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cen4;
    logic [17:0] start_addr, stop_addr, rom_addr;
    logic [3:0]  att, start, stop, busy, pipe_att, pipe_data;
    logic        loop, zero, pipe_en;
    logic [1:0]  pipe_ch;
    logic [7:0]  rom_data;

    logic [19:0] start_addr2, stop_addr2, rom_addr2;
    logic [7:0]  start2, stop2, busy2, rom_data2;
    logic        zero2, pipe_en2;
    logic [3:0]  pipe_att2, pipe_data2;
    logic [2:0]  pipe_ch2;

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ {a[23:20], a[19:16]} ^ 8'hA5;
    endfunction

    assign rom_data  = rom_byte({6'b0, rom_addr});
    assign rom_data2 = rom_byte({4'b0, rom_addr2});

    jt6295_chseq dut (
        .clk(clk), .rst(rst), .cen4(cen4),
        .start_addr(start_addr), .stop_addr(stop_addr), .att(att), .loop(loop),
        .start(start), .stop(stop), .busy(busy), .zero(zero),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pipe_en(pipe_en), .pipe_att(pipe_att), .pipe_data(pipe_data), .pipe_ch(pipe_ch)
    );

    jt6295_chseq #(.CH(8), .AW(20)) dut8 (
        .clk(clk), .rst(rst), .cen4(cen4),
        .start_addr(start_addr2), .stop_addr(stop_addr2), .att(4'd6), .loop(1'b0),
        .start(start2), .stop(stop2), .busy(busy2), .zero(zero2),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .pipe_en(pipe_en2), .pipe_att(pipe_att2), .pipe_data(pipe_data2), .pipe_ch(pipe_ch2)
    );

    int checks = 0;
    int errors = 0;
    int nt = 0;
    logic [9:0] sbq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_nib(input logic [1:0] ch, input logic [23:0] a, input logic [3:0] av,
                            input logic hi);
        logic [7:0] b;
        b = rom_byte(a);
        sbq.push_back({ch, av, hi ? b[7:4] : b[3:0]});
    endtask

    task automatic push_byte(input logic [1:0] ch, input logic [23:0] a, input logic [3:0] av);
        push_nib(ch, a, av, 1'b1);
        push_nib(ch, a, av, 1'b0);
    endtask

    // Monitor: any nibble must match the head of the scoreboard
    always @(posedge clk) begin
        logic was;
        was = cen4 && !rst;
        #1;
        if (was && pipe_en) begin
            if (sbq.size() == 0) check("spurious_pipe_en", {31'b0, pipe_en}, 32'd0);
            else check("nibble", {22'b0, pipe_ch, pipe_att, pipe_data}, {22'b0, sbq.pop_front()});
        end
    end

    // One cen4 pulse preceded by a random gap
    task automatic tick();
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
            @(negedge clk);
            cen4 = 1'b0;
        end
        @(negedge clk);
        cen4 = 1'b1;
        @(negedge clk);
        cen4 = 1'b0;
        nt++;
    endtask

    // Advance to the frame-boundary slot and present a request for its capture pulse
    task automatic req(input logic [3:0] st, input logic [3:0] sp);
        int guard;
        guard = 0;
        while (!zero && guard < 16) begin
            tick();
            guard++;
        end
        if (!zero) check("zero_timeout", {31'b0, zero}, 32'd1);
        start = st;
        stop  = sp;
        tick();
        start = '0;
        stop  = '0;
    endtask

    task automatic frames(input int n);
        repeat (n) req(4'b0, 4'b0);
    endtask

    task automatic drain(input string tag);
        frames(2);
        check({tag, "_drained"}, sbq.size(), 32'd0);
        sbq.delete();
    endtask

    task automatic set_ports(input logic [17:0] sa, input logic [17:0] ea, input logic [3:0] av,
                             input logic lp);
        start_addr = sa;
        stop_addr  = ea;
        att        = av;
        loop       = lp;
    endtask

    initial begin
        rst = 1'b1; cen4 = 1'b0; start = '0; stop = '0;
        set_ports(18'h0, 18'h0, 4'd0, 1'b0);
        start_addr2 = '0; stop_addr2 = '0; start2 = '0; stop2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pipe_en", pipe_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_zero", zero, 0);
        rst = 1'b0;

        // Request outside the capture pulse is ignored
        start = 4'b0001;
        tick();
        start = '0;
        frames(2);
        check("ignored_start", busy, 0);

        // Basic: ch1, 0x100..0x101
        set_ports(18'h100, 18'h101, 4'd3, 1'b0);
        push_byte(2'd1, 24'h100, 4'd3);
        push_byte(2'd1, 24'h101, 4'd3);
        req(4'b0010, 4'b0);
        req(4'b0, 4'b0);
        check("basic_busy", busy, 4'b0010);
        frames(5);
        check("basic_done", busy, 0);
        drain("basic");

        // Loop on ch0 at 0x200, five nibbles then stop
        set_ports(18'h200, 18'h200, 4'd9, 1'b1);
        push_byte(2'd0, 24'h200, 4'd9);
        push_byte(2'd0, 24'h200, 4'd9);
        push_nib(2'd0, 24'h200, 4'd9, 1'b1);
        req(4'b0001, 4'b0);
        frames(5);
        req(4'b0, 4'b0001);
        check("loop_busy", busy, 4'b0001);
        req(4'b0, 4'b0);
        check("loop_stopped", busy, 0);
        drain("loop");

        // Start and stop together on ch3: start wins
        set_ports(18'h300, 18'h300, 4'd4, 1'b0);
        push_byte(2'd3, 24'h300, 4'd4);
        req(4'b1000, 4'b1000);
        req(4'b0, 4'b0);
        check("coll_busy", busy, 4'b1000);
        frames(3);
        check("coll_done", busy, 0);
        drain("coll");

        // Restart a busy ch2 from a new address
        set_ports(18'h400, 18'h4FF, 4'd5, 1'b0);
        push_byte(2'd2, 24'h400, 4'd5);
        push_nib(2'd2, 24'h401, 4'd5, 1'b1);
        push_byte(2'd2, 24'h500, 4'd7);
        req(4'b0100, 4'b0);
        req(4'b0, 4'b0);
        set_ports(18'h500, 18'h500, 4'd7, 1'b0);
        frames(2);
        req(4'b0100, 4'b0);
        frames(3);
        check("restart_done", busy, 0);
        drain("restart");

        // stop below start: exactly one byte
        set_ports(18'h100, 18'h0FF, 4'd2, 1'b0);
        push_byte(2'd1, 24'h100, 4'd2);
        req(4'b0010, 4'b0);
        frames(3);
        check("rev_done", busy, 0);
        drain("rev");

        // Top of address space: ends without wrapping
        set_ports(18'h3FFFF, 18'h3FFFF, 4'd1, 1'b0);
        push_byte(2'd1, 24'h3FFFF, 4'd1);
        req(4'b0010, 4'b0);
        frames(3);
        check("top_done", busy, 0);
        drain("top");

        // Reset mid-playback with cen4 low
        set_ports(18'h200, 18'h200, 4'd9, 1'b1);
        push_byte(2'd0, 24'h200, 4'd9);
        req(4'b0001, 4'b0);
        frames(3);
        check("pre_reset_sb", sbq.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        cen4 = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_rom_addr", rom_addr, 0);
        check("mrst_pipe", {pipe_en, pipe_att, pipe_data, pipe_ch}, 0);
        check("mrst_zero", zero, 0);
        @(negedge clk);
        rst = 1'b0;
        nt = 0;
        frames(3);
        check("post_reset_busy", busy, 0);

        // CH=8/AW=20 instance: frame marker and channel wheel
        repeat (16) begin
            tick();
            check("zero4", {31'b0, zero}, {31'b0, (nt % 4) == 3});
            check("zero8", {31'b0, zero2}, {31'b0, (nt % 8) == 7});
            check("pipe_ch8", {29'b0, pipe_ch2}, 32'((nt - 2) % 8));
        end
        start_addr2 = 20'hFFFFF;
        stop_addr2  = 20'hFFFFF;
        while (!zero2) tick();
        start2 = 8'h80;
        tick();
        start2 = '0;
        repeat (16) tick();
        check("ch8_rom_addr", rom_addr2, 20'hFFFFF);
        check("ch8_busy", busy2, 8'h80);
        tick();
        begin
            logic [7:0] b;
            b = rom_byte(24'hFFFFF);
            check("ch8_nibble", {pipe_en2, pipe_ch2, pipe_att2, pipe_data2},
                  {1'b1, 3'd7, 4'd6, b[7:4]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt6295_chseq.md
JT6295_CHSEQ -- requirements
Module: jt6295_chseq

Interface
REQ-001 SHALL have parameter CH, default 4, number of time-multiplexed ADPCM channels, legal range 2..16.
REQ-002 SHALL have parameter AW, default 18, ROM byte-address width, legal range 12..24.
REQ-003 SHALL have parameter CW = clog2(CH), derived, channel-index width.
REQ-004 clk  in  1  single clock; rst  in  1  reset, synchronous and active-high.
REQ-005 cen4  in  1  slot enable; one channel slot per cen4 cycle.
REQ-006 start_addr  in  AW  first byte of sample; stop_addr  in  AW  last byte of sample (inclusive).
REQ-007 att  in  4  attenuation code; loop  in  1  loop-mode flag applied with start.
REQ-008 start  in  CH  per-channel start request; stop  in  CH  per-channel stop request.
REQ-009 busy  out  CH  channel playing; zero  out  1  high during slot CH-1 (frame boundary).
REQ-010 rom_addr  out  AW  byte address for current slot; rom_data  in  8  ROM byte, valid one slot after rom_addr.
REQ-011 pipe_en  out  1  nibble valid; pipe_att  out  4; pipe_data  out  4; pipe_ch  out  CW  channel owning pipe_* outputs.

Function
REQ-012 Slot index SHALL advance 0,1,..,CH-1,0 on each cen4 cycle; with cen4 low, no state SHALL change.
REQ-013 zero SHALL equal (slot index == CH-1), combinational from the registered index.
REQ-014 start/stop vectors SHALL be captured on the cen4 cycle where zero=1; bit k SHALL act in slot k of the following frame; requests outside that cycle SHALL be ignored.
REQ-015 Per-channel state: nibble counter (AW+1 bits), stop address, loop start address, att, loop flag, busy.
REQ-016 Start in slot k: counter = {start_addr,0}, loop start = start_addr, stop/att/loop loaded from ports, busy[k]=1, no nibble emitted for that slot.
REQ-017 Start on an already busy channel SHALL restart it per REQ-016; start and stop on the same channel together: start wins.
REQ-018 Stop in slot k (no start): busy[k]=0, no nibble emitted, counter unchanged.
REQ-019 Busy slot k otherwise: rom_addr = counter[AW:1]; nibble emitted; counter += 1.
REQ-020 End test: if counter[0]=1 and counter[AW:1] >= stop address, the channel ends after that nibble: loop=0 -> busy[k]=0; loop=1 -> counter = {loop start,0}, busy stays 1.
REQ-021 stop_addr < start_addr SHALL play exactly one byte (two nibbles), then end or loop per REQ-020.
REQ-022 Counter increment SHALL wrap modulo 2^(AW+1); the end test is evaluated before the increment.
REQ-023 Idle slot: rom_addr holds last value, no nibble emitted.
REQ-024 Nibble select: counter[0]=0 -> rom_data[7:4], counter[0]=1 -> rom_data[3:0].
REQ-025 Latency: pipe_* for slot k SHALL update on the cen4 cycle ending slot k+1 (mod CH); pipe_ch=k, pipe_att=att of k, pipe_en=1 only if a nibble was emitted in slot k.
REQ-026 busy[k] SHALL update on the cen4 cycle ending slot k.

Reset
REQ-027 rst high on any clk edge SHALL clear slot index to 0, busy, all per-channel state, captured requests, rom_addr, pipe_en, pipe_att, pipe_data and pipe_ch to 0, regardless of cen4.
REQ-028 Reset mid-playback SHALL abort all channels; no pipe_en=1 SHALL appear until a new start completes REQ-016.

Verification
REQ-029 Basic: CH=4, start=4'b0010, start_addr=0x100, stop_addr=0x101, att=3, loop=0 -> ch1 emits 4 nibbles from 0x100,0x100,0x101,0x101 (high,low,high,low), pipe_ch=1, pipe_att=3, then busy[1]=0.
REQ-030 Loop: start_addr=0x200, stop_addr=0x200, loop=1 -> ch0 repeats rom 0x200 high/low indefinitely, busy[0] stays 1 until stop=4'b0001, then next emission absent.
REQ-031 Collision: start=stop=4'b1000 in same frame -> ch3 starts; start on a busy ch2 -> counter reloads, next nibble from new start_addr.
REQ-032 Boundary: stop_addr=0x0FF < start_addr=0x100 -> exactly 2 nibbles then busy=0; counter at 0x3FFFF odd byte with stop=0x3FFFF -> ends, no wrap emission.
REQ-033 Parameters: CH=8, AW=20 -> zero every 8th cen4, pipe_ch cycles 0..7, addresses up to 0xFFFFF reachable.
REQ-034 Reset mid-playback with cen4 held low -> all outputs 0 on next clk edge; cen4 gaps of random length do not alter emitted nibble sequence.
